alu_rv_exec: RTL and testbench

//  Parametrised RV32I/RV64I execute stage with valid/ready handshakes on both sides.

---
 rtl/alu_rv_exec.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_rv_exec.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rv_exec.sv
// alu_rv_exec: RV32I/RV64I execute stage with a valid/ready handshake on each side.
//   It decodes one instruction and produces the ALU result, the register write-back
//   and the control-transfer target. Shifts run on an iterative shifter that moves
//   SHIFT_STEP bits per cycle; every other instruction takes one cycle.
// Ports:
//   clock, reset                  clock; synchronous active-high reset
//   in_valid/in_ready             input handshake (in_ready only in IDLE)
//   instruction, rs1_value,
//   rs2_value, pc                 operands, sampled only on the accept edge
//   out_valid/out_ready           output handshake; result held until out_ready
//   rd_index, rd_we, rd_value     register write-back
//   next_pc_valid, next_pc        resolved control transfer (JAL/JALR/BRANCH)
//   illegal                       unsupported encoding or misaligned target
module alu_rv_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rd_index,
  output logic            rd_we,
  output logic [XLEN-1:0] rd_value,
  output logic            next_pc_valid,
  output logic [XLEN-1:0] next_pc,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);  // shamt width
  localparam int CW  = SHW + 1;       // wide enough to hold SHIFT_STEP == XLEN

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef struct packed {
    logic [4:0]      rd_index;
    logic            rd_we;
    logic [XLEN-1:0] rd_value;
    logic            npc_valid;
    logic [XLEN-1:0] npc;
    logic            illegal;
  } res_t;

  typedef struct packed {
    logic           go;     // needs the iterative shifter
    logic           left;
    logic           arith;
    logic [SHW-1:0] amt;
  } shreq_t;

  state_t state_q, state_d;
  logic   accept;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;

  // ---------------- decode / single-cycle datapath ----------------
  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_b, imm_j, imm_u, op_b, alu_val;
  logic [SHW-1:0]  shamt;
  logic            is_op, is_sub;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign f3     = instruction[14:12];
  assign f7     = instruction[31:25];
  assign is_op  = (opcode == OPC_OP);
  assign is_sub = is_op & instruction[30];

  assign imm_i = XLEN'($signed(instruction[31:20]));
  assign imm_b = XLEN'($signed({instruction[31], instruction[7], instruction[30:25],
                                instruction[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({instruction[31], instruction[19:12], instruction[20],
                                instruction[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({instruction[31:12], 12'b0}));

  assign op_b  = is_op ? rs2_value : imm_i;
  assign shamt = is_op ? rs2_value[SHW-1:0] : instruction[20 +: SHW];

  always_comb begin
    alu_val = '0;
    case (f3)
      3'b000:  alu_val = is_sub ? rs1_value - op_b : rs1_value + op_b;
      3'b010:  alu_val = XLEN'($signed(rs1_value) < $signed(op_b));
      3'b011:  alu_val = XLEN'(rs1_value < op_b);
      3'b100:  alu_val = rs1_value ^ op_b;
      3'b110:  alu_val = rs1_value | op_b;
      3'b111:  alu_val = rs1_value & op_b;
      default: alu_val = rs1_value;  // shifts: shamt==0 result
    endcase
  end

  res_t            dec;
  shreq_t          shreq;
  logic            ok, ctl, is_br, taken;
  logic [XLEN-1:0] val, tgt;

  always_comb begin
    dec   = '0;
    shreq = '0;
    ok    = 1'b1;
    ctl   = 1'b0;
    is_br = 1'b0;
    taken = 1'b0;
    val   = '0;
    tgt   = '0;
    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        val = alu_val;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if (is_op)
            ok = (f7 == 7'h00) || (f3 == 3'b101 && f7 == 7'h20);
          else if (f3 == 3'b001)
            ok = (instruction[31:20+SHW] == '0);
          else  // SRLI/SRAI: only bit 30 may be set above shamt
            ok = !instruction[31] && (instruction[29:20+SHW] == '0);
          shreq.go    = ok && (shamt != '0);
          shreq.left  = (f3 == 3'b001);
          shreq.arith = instruction[30];
          shreq.amt   = shamt;
        end else if (is_op) begin
          ok = (f7 == 7'h00) || (f3 == 3'b000 && f7 == 7'h20);
        end
      end
      OPC_LUI:   val = imm_u;
      OPC_AUIPC: val = pc + imm_u;
      OPC_JAL: begin
        ctl = 1'b1;
        val = pc + XLEN'(4);
        tgt = pc + imm_j;
      end
      OPC_JALR: begin
        ok  = (f3 == 3'b000);
        ctl = 1'b1;
        val = pc + XLEN'(4);
        tgt = (rs1_value + imm_i) & ~XLEN'(1);
      end
      OPC_BRANCH: begin
        is_br = 1'b1;
        case (f3)
          3'b000:  taken = (rs1_value == rs2_value);
          3'b001:  taken = (rs1_value != rs2_value);
          3'b100:  taken = ($signed(rs1_value) <  $signed(rs2_value));
          3'b101:  taken = ($signed(rs1_value) >= $signed(rs2_value));
          3'b110:  taken = (rs1_value <  rs2_value);
          3'b111:  taken = (rs1_value >= rs2_value);
          default: ok    = 1'b0;
        endcase
        tgt = taken ? pc + imm_b : pc + XLEN'(4);
      end
      default: ok = 1'b0;
    endcase

    if (!ok) begin
      dec         = '0;
      dec.illegal = 1'b1;
      shreq.go    = 1'b0;
    end else if (is_br) begin
      dec.npc_valid = 1'b1;
      dec.npc       = tgt;
      dec.illegal   = tgt[1];
    end else begin
      // a misaligned jump still reports its target but must not write rd
      dec.rd_index  = rd;
      dec.rd_value  = val;
      dec.rd_we     = (rd != 5'd0) && !(ctl && tgt[1]);
      dec.npc_valid = ctl;
      dec.npc       = tgt;
      dec.illegal   = ctl && tgt[1];
    end
  end

  // ---------------- iterative shifter ----------------
  logic [XLEN-1:0] sh_val, sh_nxt, fill;
  logic [CW-1:0]   sh_rem, step;
  logic            sh_left, sh_arith, sh_sign, sh_last;

  // last partial step moves only what is left
  assign step    = (sh_rem < CW'(SHIFT_STEP)) ? sh_rem : CW'(SHIFT_STEP);
  assign sh_last = (sh_rem == step);
  // arithmetic fill comes from the sign captured at accept time
  assign fill    = (sh_arith && sh_sign) ? ~({XLEN{1'b1}} >> step) : '0;
  assign sh_nxt  = sh_left ? (sh_val << step) : ((sh_val >> step) | fill);

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = shreq.go ? SHIFT : DONE;
      SHIFT:   if (sh_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  res_t res_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      res_q    <= '0;
      sh_val   <= '0;
      sh_rem   <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
      sh_sign  <= 1'b0;
    end else if (accept) begin
      res_q    <= dec;
      sh_val   <= rs1_value;
      sh_rem   <= CW'(shreq.amt);
      sh_left  <= shreq.left;
      sh_arith <= shreq.arith;
      sh_sign  <= rs1_value[XLEN-1];
    end else if (state_q == SHIFT) begin
      sh_val         <= sh_nxt;
      sh_rem         <= sh_rem - step;
      res_q.rd_value <= sh_nxt;
    end
  end

  // outputs are forced to zero outside DONE so IDLE/SHIFT look like reset
  always_comb begin
    out_valid     = (state_q == DONE);
    rd_index      = '0;
    rd_we         = 1'b0;
    rd_value      = '0;
    next_pc_valid = 1'b0;
    next_pc       = '0;
    illegal       = 1'b0;
    if (out_valid) begin
      rd_index      = res_q.rd_index;
      rd_we         = res_q.rd_we;
      rd_value      = res_q.rd_value;
      next_pc_valid = res_q.npc_valid;
      next_pc       = res_q.npc;
      illegal       = res_q.illegal;
    end
  end

endmodule

// File: tb/tb_alu_rv_exec.sv
// tb_alu_rv_exec: directed + randomized bench for alu_rv_exec (XLEN=32, SHIFT_STEP=4),
// checked against an instruction-level reference model.
module tb_alu_rv_exec;

  localparam int XLEN = 32;
  localparam int STEP = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     instruction = '0;
  logic [XLEN-1:0] rs1_value = '0, rs2_value = '0, pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [4:0]      rd_index;
  logic            rd_we;
  logic [XLEN-1:0] rd_value;
  logic            next_pc_valid;
  logic [XLEN-1:0] next_pc;
  logic            illegal;

  int checks = 0;
  int failures = 0;

  alu_rv_exec #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .rs1_value(rs1_value), .rs2_value(rs2_value), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_index(rd_index), .rd_we(rd_we), .rd_value(rd_value),
    .next_pc_valid(next_pc_valid), .next_pc(next_pc), .illegal(illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [4:0]  rd_index;
    logic        rd_we;
    logic [31:0] rd_value;
    logic        npv;
    logic [31:0] npc;
    logic        ill;
    int          lat;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the instruction means architecturally, in RV32I terms.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, b, p);
    exp_t e;
    logic [31:0] ii, ib, ij, iu, v, t;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  sh;
    bit ok, ctl, br, tk, shift;
    e = '0; e.lat = 1;
    ii = {{20{ins[31]}}, ins[31:20]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    iu = {ins[31:12], 12'h000};
    f3 = ins[14:12]; f7 = ins[31:25];
    ok = 1; ctl = 0; br = 0; tk = 0; shift = 0; v = 0; t = 0; sh = 0;
    case (ins[6:0])
      7'h33: begin
        sh = b[4:0];
        case (f3)
          3'd0: if (f7 == 7'h00) v = a + b; else if (f7 == 7'h20) v = a - b; else ok = 0;
          3'd1: begin shift = 1; if (f7 == 7'h00) v = a << sh; else ok = 0; end
          3'd5: begin
            shift = 1;
            if (f7 == 7'h00) v = a >> sh;
            else if (f7 == 7'h20) v = $signed(a) >>> sh;
            else ok = 0;
          end
          default: begin
            if (f7 != 7'h00) ok = 0;
            case (f3)
              3'd2: v = ($signed(a) < $signed(b)) ? 1 : 0;
              3'd3: v = (a < b) ? 1 : 0;
              3'd4: v = a ^ b;
              3'd6: v = a | b;
              default: v = a & b;
            endcase
          end
        endcase
      end
      7'h13: begin
        sh = ins[24:20];
        case (f3)
          3'd0: v = a + ii;
          3'd1: begin shift = 1; if (f7 == 7'h00) v = a << sh; else ok = 0; end
          3'd2: v = ($signed(a) < $signed(ii)) ? 1 : 0;
          3'd3: v = (a < ii) ? 1 : 0;
          3'd4: v = a ^ ii;
          3'd5: begin
            shift = 1;
            if (f7 == 7'h00) v = a >> sh;
            else if (f7 == 7'h20) v = $signed(a) >>> sh;
            else ok = 0;
          end
          3'd6: v = a | ii;
          default: v = a & ii;
        endcase
      end
      7'h37: v = iu;
      7'h17: v = p + iu;
      7'h6F: begin ctl = 1; v = p + 4; t = p + ij; end
      7'h67: begin ok = (f3 == 0); ctl = 1; v = p + 4; t = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        br = 1;
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: ok = 0;
        endcase
        t = tk ? p + ib : p + 4;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      e.ill = 1;
    end else if (br) begin
      e.npv = 1; e.npc = t; e.ill = t[1];
    end else begin
      e.rd_index = ins[11:7];
      e.rd_value = v;
      e.rd_we = (ins[11:7] != 0);
      if (ctl) begin
        e.npv = 1; e.npc = t;
        if (t[1]) begin e.ill = 1; e.rd_we = 0; end
      end
      if (shift && sh != 0) e.lat = 1 + (int'(sh) + STEP - 1) / STEP;
    end
    return e;
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, 5'd1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  // Issue one instruction, measure latency, compare the result, optionally hold
  // out_ready low for 'hold' cycles while offering another instruction.
  task automatic run_op(input string tag, input logic [31:0] ins,
                        input logic [31:0] a, b, p, input int hold);
    exp_t e;
    int lat;
    logic [75:0] snap;
    e = model(ins, a, b, p);
    @(negedge clock);
    in_valid = 1'b1; instruction = ins; rs1_value = a; rs2_value = b; pc = p;
    chk({tag, ".in_ready"}, in_ready, 1);
    @(posedge clock); #1;
    // later input changes must be ignored
    in_valid = 1'b0; instruction = $urandom; rs1_value = $urandom;
    rs2_value = $urandom; pc = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, e.lat);
    chk({tag, ".rd_index"}, rd_index, e.rd_index);
    chk({tag, ".rd_we"}, rd_we, e.rd_we);
    chk({tag, ".rd_value"}, rd_value, e.rd_value);
    chk({tag, ".next_pc_valid"}, next_pc_valid, e.npv);
    chk({tag, ".next_pc"}, next_pc, e.npc);
    chk({tag, ".illegal"}, illegal, e.ill);
    if (hold > 0) begin
      snap = {out_valid, rd_index, rd_we, rd_value, next_pc_valid, next_pc, illegal, 1'b0};
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; instruction = enc_i(12'h001, 3'd0, 5'd9, 7'h13);
        @(posedge clock); #1;
        chk({tag, ".hold_outputs"},
            {out_valid, rd_index, rd_we, rd_value, next_pc_valid, next_pc, illegal, 1'b0}, snap);
        chk({tag, ".hold_in_ready"}, in_ready, 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({tag, ".drain_out_valid"}, out_valid, 0);
    chk({tag, ".drain_in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] ins, a, b, p;
    logic        seen;
    int          k;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset.in_ready", in_ready, 1);
    chk("reset.outputs", {out_valid, rd_index, rd_we, rd_value, next_pc_valid, next_pc, illegal}, 0);
    @(negedge clock); reset = 1'b0;

    // directed scenarios
    run_op("addi_m1", enc_i(12'hFFF, 3'd0, 5'd5, 7'h13), 32'h1234_5678, 0, 32'h10, 0);
    run_op("sra31", enc_r(7'h20, 3'd5, 5'd6), 32'h8000_0000, 32'd31, 32'h14, 0);
    run_op("beq_taken", enc_b(13'h1FF8, 3'd0), 32'd7, 32'd7, 32'h100, 0);
    run_op("beq_fall", enc_b(13'h1FF8, 3'd0), 32'd7, 32'd8, 32'h100, 0);
    run_op("jalr_mis", enc_i(12'd2, 3'd0, 5'd1, 7'h67), 32'h1001, 0, 32'h40, 0);
    run_op("jalr_ok", enc_i(12'd3, 3'd0, 5'd1, 7'h67), 32'h1001, 0, 32'h40, 0);
    run_op("add_hold", enc_r(7'h00, 3'd0, 5'd3), 32'd5, 32'd6, 32'h0, 5);
    run_op("srl_zero", enc_r(7'h00, 3'd5, 5'd7), 32'hF000_000F, 32'd32, 32'h0, 0);
    run_op("lui_neg", {20'h80000, 5'd2, 7'h37}, 0, 0, 32'h0, 0);
    run_op("illegal_7f", 32'h0000_007F, 32'd1, 32'd2, 32'h20, 0);

    // reset during the third SHIFT cycle discards the shift
    @(negedge clock);
    in_valid = 1'b1; instruction = enc_r(7'h00, 3'd1, 5'd4); rs1_value = 1; rs2_value = 31;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("rst_shift.busy", in_ready, 0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_shift.in_ready", in_ready, 1);
    chk("rst_shift.outputs", {out_valid, rd_index, rd_we, rd_value, next_pc_valid, next_pc, illegal}, 0);
    @(negedge clock); reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_shift.no_result", seen, 0);

    // randomized instructions
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 7);
      ins = $urandom;
      case (k)
        0, 1: begin
          ins[6:0] = (k == 0) ? 7'h33 : 7'h13;
          case ($urandom_range(0, 3))
            0, 1: ins[31:25] = 7'h00;
            2:    ins[31:25] = 7'h20;
            default: ;
          endcase
        end
        2: ins[6:0] = 7'h37;
        3: ins[6:0] = 7'h17;
        4: ins[6:0] = 7'h6F;
        5: begin ins[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) ins[14:12] = 3'd0; end
        6: ins[6:0] = 7'h63;
        default: ;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      p = $urandom & 32'hFFFF_FFFC;
      run_op("rand", ins, a, b, p, (n % 16 == 5) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
